// File: rtl/conn_table_if.sv
// Tuple lookup request / connection ID response bundle between the
// ingress rewriter (master) and the connection table (slave).
interface conn_table_if;
  logic [127:0] tuple_data_i;
  logic         tuple_valid_i;
  logic [15:0]  conn_data_o;
  logic         conn_valid_o;
  logic         conn_full_o;

  modport master (
    output tuple_data_i,
    output tuple_valid_i,
    input  conn_data_o,
    input  conn_valid_o,
    input  conn_full_o
  );

  modport slave (
    input  tuple_data_i,
    input  tuple_valid_i,
    output conn_data_o,
    output conn_valid_o,
    output conn_full_o
  );
endinterface

// File: rtl/conn_table.sv
// NAT connection table: hashes a 5-tuple, linear-probes a register table
// and returns the slot index as connection ID, inserting on a miss.
module conn_table #(
  parameter int HASH_LEN = 6
) (
  input  logic                clk,
  input  logic                reset,
  conn_table_if.slave         bus,
  input  logic                clear_i,
  output logic [HASH_LEN:0]   entry_count_o
);

  localparam int KW  = 104;
  localparam int N   = 1 << HASH_LEN;
  localparam int NCH = (KW + HASH_LEN - 1) / HASH_LEN;
  localparam int KPW = NCH * HASH_LEN;
  localparam logic [HASH_LEN-1:0] LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    HASH,
    PROBE,
    RESP,
    WAIT_DROP
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0]       key_q;
  logic [HASH_LEN-1:0] loc_q;
  logic [HASH_LEN-1:0] probe_cnt_q;
  logic [N-1:0]        valid_q;
  logic [KW-1:0]       keys [N];
  logic [HASH_LEN:0]   entry_cnt_q;
  logic [15:0]         data_q;
  logic                full_q;
  logic                clear_pend_q;

  logic [KPW-1:0]      key_pad;
  logic [HASH_LEN-1:0] hash;
  logic                slot_valid;
  logic                hit;
  logic                empty;
  logic                last;
  logic                do_clear;
  logic                wr_en;
  logic                unused_tuple;

  assign unused_tuple = ^bus.tuple_data_i[127:KW];

  // Top chunk is zero-padded by widening the key before folding.
  assign key_pad = KPW'(key_q);

  always_comb begin
    hash = '0;
    for (int k = 0; k < NCH; k++) begin
      hash = hash ^ key_pad[k*HASH_LEN +: HASH_LEN];
    end
  end

  assign slot_valid = valid_q[loc_q];
  assign hit        = slot_valid && (keys[loc_q] == key_q);
  assign empty      = !slot_valid;
  assign last       = (probe_cnt_q == LAST);
  assign do_clear   = clear_pend_q || clear_i;
  assign wr_en      = (state_q == PROBE) && empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!do_clear && bus.tuple_valid_i) begin
          state_d = HASH;
        end
      end
      HASH: begin
        state_d = PROBE;
      end
      PROBE: begin
        if (hit || empty || last) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!bus.tuple_valid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q        <= '0;
      loc_q        <= '0;
      probe_cnt_q  <= '0;
      valid_q      <= '0;
      entry_cnt_q  <= '0;
      data_q       <= '0;
      full_q       <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      if (state_q != IDLE && clear_i) begin
        clear_pend_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (do_clear) begin
            valid_q      <= '0;
            entry_cnt_q  <= '0;
            clear_pend_q <= 1'b0;
          end else if (bus.tuple_valid_i) begin
            key_q <= bus.tuple_data_i[KW-1:0];
          end
        end
        HASH: begin
          loc_q       <= hash;
          probe_cnt_q <= '0;
        end
        PROBE: begin
          if (hit) begin
            data_q <= 16'(loc_q);
            full_q <= 1'b0;
          end else if (empty) begin
            valid_q[loc_q] <= 1'b1;
            entry_cnt_q    <= entry_cnt_q + (HASH_LEN+1)'(1);
            data_q         <= 16'(loc_q);
            full_q         <= 1'b0;
          end else begin
            if (last) begin
              data_q <= 16'hFFFF;
              full_q <= 1'b1;
            end
            loc_q       <= loc_q + HASH_LEN'(1);
            probe_cnt_q <= probe_cnt_q + HASH_LEN'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Key storage carries no reset; valid_q alone decides occupancy.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      keys[loc_q] <= key_q;
    end
  end

  assign bus.conn_valid_o = (state_q == RESP);
  assign bus.conn_data_o  = data_q;
  assign bus.conn_full_o  = full_q;
  assign entry_count_o    = entry_cnt_q;

endmodule

// File: tb/tb_conn_table.sv
// Directed bench for conn_table: vector table plus sequences for
// table-full, async reset, held valid and clear during probe.
module tb_conn_table;
  localparam int HL = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_i;
  logic [HL:0]   entry_count_o;

  conn_table_if bus();

  conn_table #(.HASH_LEN(HL)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .clear_i(clear_i),
    .entry_count_o(entry_count_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        name;
    logic [127:0] t;
    logic [15:0]  d;
    logic         f;
    int           cnt;
    int           lat;
  } vec_t;

  vec_t vt[7];

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] tup(logic [31:0] sip, logic [31:0] dip,
                                       logic [15:0] sp, logic [15:0] dp,
                                       logic [7:0] pr);
    return {24'h0, sip, dip, sp, dp, pr};
  endfunction

  task automatic req(input logic [127:0] t, input int hold,
                     output logic [15:0] d, output logic f,
                     output int cnt, output int lat, output int extra);
    @(negedge clk);
    bus.tuple_data_i  = t;
    bus.tuple_valid_i = 1'b1;
    lat   = 0;
    extra = 0;
    d     = '0;
    f     = 1'b0;
    cnt   = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.conn_valid_o) break;
    end
    if (!bus.conn_valid_o) begin
      check("response_timeout", 32'(lat), 32'd0);
    end
    d   = bus.conn_data_o;
    f   = bus.conn_full_o;
    cnt = int'(entry_count_o);
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (bus.conn_valid_o) extra++;
    end
    bus.tuple_valid_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.conn_valid_o) extra++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    logic        f;
    int          cnt;
    int          lat;
    int          extra;

    vt[0] = '{"insert_A",   tup(0, 0, 0, 16'h0000, 8'h06), 16'd6,  1'b0, 1, 3};
    vt[1] = '{"relookup_A", tup(0, 0, 0, 16'h0000, 8'h06), 16'd6,  1'b0, 1, 3};
    vt[2] = '{"collide_B",  tup(0, 0, 0, 16'h0010, 8'h46), 16'd7,  1'b0, 2, 4};
    vt[3] = '{"relookup_B", tup(0, 0, 0, 16'h0010, 8'h46), 16'd7,  1'b0, 2, 4};
    vt[4] = '{"chain_C",    tup(0, 0, 0, 16'h0000, 8'h07), 16'd8,  1'b0, 3, 4};
    vt[5] = '{"home_63",    tup(0, 0, 0, 16'h0000, 8'h3F), 16'd63, 1'b0, 4, 3};
    vt[6] = '{"home_1",     tup(0, 0, 0, 16'h0000, 8'h40), 16'd1,  1'b0, 5, 3};

    reset             = 1'b1;
    clear_i           = 1'b0;
    bus.tuple_data_i  = '0;
    bus.tuple_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.conn_valid_o), 32'd0);
    check("rst_data",  32'(bus.conn_data_o),  32'd0);
    check("rst_full",  32'(bus.conn_full_o),  32'd0);
    check("rst_count", 32'(entry_count_o),    32'd0);

    for (int i = 0; i < 7; i++) begin
      req(vt[i].t, 0, d, f, cnt, lat, extra);
      check({vt[i].name, "_data"},  32'(d),     32'(vt[i].d));
      check({vt[i].name, "_full"},  32'(f),     32'(vt[i].f));
      check({vt[i].name, "_count"}, 32'(cnt),   32'(vt[i].cnt));
      check({vt[i].name, "_lat"},   32'(lat),   32'(vt[i].lat));
      check({vt[i].name, "_extra"}, 32'(extra), 32'd0);
    end

    // Fill every slot at its home index, then overflow.
    apply_reset();
    for (int i = 0; i < 64; i++) begin
      req(tup(0, 0, 0, 0, 8'(i)), 0, d, f, cnt, lat, extra);
      check($sformatf("fill_%0d_data", i), 32'(d), 32'(i));
      check($sformatf("fill_%0d_lat", i), 32'(lat), 32'd3);
    end
    check("fill_count", 32'(entry_count_o), 32'd64);
    req(tup(0, 0, 0, 0, 8'h80), 0, d, f, cnt, lat, extra);
    check("full_data",  32'(d),   32'hFFFF);
    check("full_flag",  32'(f),   32'd1);
    check("full_lat",   32'(lat), 32'd66);
    check("full_count", 32'(cnt), 32'd64);
    req(tup(0, 0, 0, 0, 8'h05), 0, d, f, cnt, lat, extra);
    check("full_exist_data", 32'(d),   32'd5);
    check("full_exist_flag", 32'(f),   32'd0);
    check("full_exist_lat",  32'(lat), 32'd3);

    // Async reset in the middle of a long probe chain.
    @(negedge clk);
    bus.tuple_data_i  = tup(0, 0, 0, 0, 8'h80);
    bus.tuple_valid_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.tuple_valid_i = 1'b0;
    #1;
    check("arst_valid", 32'(bus.conn_valid_o), 32'd0);
    check("arst_data",  32'(bus.conn_data_o),  32'd0);
    check("arst_full",  32'(bus.conn_full_o),  32'd0);
    check("arst_count", 32'(entry_count_o),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    req(tup(0, 0, 0, 0, 8'h80), 0, d, f, cnt, lat, extra);
    check("post_rst_data",  32'(d),   32'd2);
    check("post_rst_lat",   32'(lat), 32'd3);
    check("post_rst_count", 32'(cnt), 32'd1);

    // Valid held long after the response.
    req(tup(0, 0, 0, 0, 8'h06), 10, d, f, cnt, lat, extra);
    check("hold_data",  32'(d),     32'd6);
    check("hold_extra", 32'(extra), 32'd0);
    check("hold_count", 32'(cnt),   32'd2);

    // Clear pulsed while the lookup is in PROBE.
    @(negedge clk);
    bus.tuple_data_i  = tup(0, 0, 0, 0, 8'h81);
    bus.tuple_valid_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check("clr_resp_valid", 32'(bus.conn_valid_o), 32'd1);
    check("clr_resp_data",  32'(bus.conn_data_o),  32'd3);
    check("clr_resp_count", 32'(entry_count_o),    32'd3);
    bus.tuple_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_count", 32'(entry_count_o), 32'd0);
    req(tup(0, 0, 0, 0, 8'h06), 0, d, f, cnt, lat, extra);
    check("clr_reins_data",  32'(d),   32'd6);
    check("clr_reins_lat",   32'(lat), 32'd3);
    check("clr_reins_count", 32'(cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conn_table.md
# conn_table

Connection-table responder for the NAT datapath. It accepts a 5-tuple lookup request from the packet-rewrite stage over the tuple/conn handshake and hashes the tuple to a table index. It then linear-probes a register-based table and returns the connection ID, which is the slot index, inserting the tuple on a miss. It is the slave end of the `tuple_data` / `conn_data` interface driven by the ingress parser/rewriter.

## Interface
- `HASH_LEN`, 6: index width; the table has 2^HASH_LEN entries; legal range 1..8.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tuple_data_i`  in  128  request tuple:
  - [127:104] ignored
  - [103:72] src_ip
  - [71:40] dst_ip
  - [39:24] src_port
  - [23:8] dst_port
  - [7:0] protocol
- `tuple_valid_i`  in  1  request level; requester holds it high with stable data until it has seen `conn_valid_o`.
- `conn_data_o`  out  16  connection ID, zero-extended from HASH_LEN bits; 16'hFFFF when the table is full.
- `conn_valid_o`  out  1  one-cycle response strobe.
- `conn_full_o`  out  1  qualifies `conn_data_o`; high with `conn_valid_o` when there was no hit and no free slot.
- `clear_i`  in  1  synchronous pulse; invalidates all entries.
- `entry_count_o`  out  HASH_LEN+1  number of valid entries.

## Operation
- Key K = `tuple_data_i[103:0]`, captured in IDLE.
- Hash H = XOR of chunks K[k*HASH_LEN +: HASH_LEN] for k = 0..ceil(104/HASH_LEN)-1. The top partial chunk is zero-padded.
- Table storage per entry: `valid` bit (async-reset to 0) and a 104-bit key (not reset).
- State machine IDLE → HASH → PROBE → RESP → WAIT_DROP → IDLE:
  - **IDLE:**
    - If a clear is pending or `clear_i`=1: clear all `valid` bits, set `entry_count_o`=0, and stay in IDLE. Clear has priority over a request in the same cycle.
    - Else if `tuple_valid_i`=1: capture K and go to HASH.
  - **HASH:** register H into `loc`, set `probe_cnt`=0, go to PROBE.
  - **PROBE:** one slot per cycle at `loc`.
    - Hit (valid and key==K): result=`loc`, full=0.
    - Empty (!valid): write K, set valid, `entry_count_o`+1; result=`loc`, full=0.
    - Otherwise: `loc`+1, wrapping mod 2^HASH_LEN, and `probe_cnt`+1.
    - If `probe_cnt` reaches 2^HASH_LEN-1 with no hit/empty on that probe: result=16'hFFFF, full=1.
    - Any resolution goes to RESP.
  - **RESP:** `conn_valid_o`=1 for exactly this cycle; `conn_data_o` and `conn_full_o` are valid. Go to WAIT_DROP.
  - **WAIT_DROP:** stay until `tuple_valid_i`=0, then go to IDLE. This prevents re-serving a request whose valid is still high.
- `clear_i` outside IDLE sets a `clear_pending` flag. The clear is applied on the next IDLE cycle, then the flag is cleared.
- `conn_data_o` and `conn_full_o` hold their last values between responses.
- `entry_count_o` saturates at 2^HASH_LEN by construction; no insertion happens when full.

## Timing
- Reset values: state=IDLE, `conn_valid_o`=0, `conn_data_o`=0, `conn_full_o`=0, `entry_count_o`=0, all `valid`=0, `clear_pending`=0.
- Let cycle 0 be the IDLE cycle in which `tuple_valid_i`=1 is sampled. For a request resolved on probe n (n=0 is the home slot), `conn_valid_o` is high in cycle 3+n.
- Worst-case latency: 3+2^HASH_LEN-1 cycles.
- Minimum request-to-request spacing: `tuple_valid_i` low for at least one cycle, sampled in WAIT_DROP.
- Reset asserted mid-operation aborts the lookup immediately. No `conn_valid_o` is produced, and the table is empty afterwards.
- A table write and the `entry_count_o` increment become visible in the cycle after the resolving PROBE cycle.

## Test plan
All scenarios use HASH_LEN=6.
- **Reset:** assert `reset` asynchronously mid-PROBE. Required: outputs drop to their reset values without a clock edge; a following request for any tuple returns its home index.
- **Insert:** tuple A (all zero except protocol=8'h06, H=6). Required: `conn_valid_o` pulse at cycle 3, `conn_data_o`=16'h0006, `conn_full_o`=0, `entry_count_o`=1.
- **Re-lookup:** drop valid, then re-request A. Required: ID 6 at cycle 3; `entry_count_o` stays 1.
- **Collision:** tuple B (dst_port=16'h0010, protocol=8'h46, H=6). Required: ID 16'h0007 at cycle 4; `entry_count_o`=2. Requesting B again also returns 7 at cycle 4.
- **Table full:** fill all 64 slots, then request a new tuple. Required: after 64 probes, `conn_valid_o` with `conn_data_o`=16'hFFFF and `conn_full_o`=1; an existing tuple still returns its ID.
- **Handshake and clear:**
  - Hold `tuple_valid_i` high for 10 cycles after the response. Required: exactly one `conn_valid_o` pulse.
  - Pulse `clear_i` during PROBE. Required: the current response completes normally, then `entry_count_o`=0 on the first IDLE cycle, and A re-inserts at 6.
